// File: rtl/div_issue.sv
// Division issue controller: latches operands, handshakes with the 32-bit
// multicycle divider, stalls the pipeline and emits a one-cycle HI/LO write.
module div_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic        sign_r;
  logic [31:0] op1_r;
  logic [31:0] op2_r;
  logic        whilo_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  // Control FSM: operand latch on acceptance, result capture on divider ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      sign_r  <= 1'b0;
      op1_r   <= 32'd0;
      op2_r   <= 32'd0;
      whilo_r <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      whilo_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // Operands only move here, so the divider sees them stable for its whole run
          if (div_req_i && !flush_i) begin
            sign_r  <= div_signed_i;
            op1_r   <= reg1_i;
            op2_r   <= reg2_i;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (flush_i) begin
            state_r <= IDLE;
          end else if (div_ready_i) begin
            hi_r    <= div_result_i[63:32];
            lo_r    <= div_result_i[31:0];
            whilo_r <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Divider handshake and stall request decoded from the current state
  always_comb begin
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    stallreq_o  = 1'b0;
    case (state_r)
      IDLE: begin
        stallreq_o = div_req_i && !flush_i;
      end
      BUSY: begin
        div_start_o = !flush_i;
        div_annul_o = flush_i;
        stallreq_o  = !flush_i;
      end
      DONE: begin
        // Stall drops here so the instruction retires alongside the HI/LO write
        stallreq_o = 1'b0;
      end
      default: begin
        stallreq_o = 1'b0;
      end
    endcase
  end

  assign div_signed_o  = sign_r;
  assign div_opdata1_o = op1_r;
  assign div_opdata2_o = op2_r;
  assign whilo_o       = whilo_r;
  assign hi_o          = hi_r;
  assign lo_o          = lo_r;

endmodule

// File: tb/tb_div_issue.sv
// Self-checking bench for div_issue: a cycle-timed divider stand-in plus a
// transaction-level reference model compared on every cycle.
module tb_div_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req_i;
  logic        div_signed_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic        flush_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        stallreq_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  div_issue dut (
    .clk           (clk),
    .rst           (rst),
    .div_req_i     (div_req_i),
    .div_signed_i  (div_signed_i),
    .reg1_i        (reg1_i),
    .reg2_i        (reg2_i),
    .flush_i       (flush_i),
    .div_result_i  (div_result_i),
    .div_ready_i   (div_ready_i),
    .div_start_o   (div_start_o),
    .div_annul_o   (div_annul_o),
    .div_signed_o  (div_signed_o),
    .div_opdata1_o (div_opdata1_o),
    .div_opdata2_o (div_opdata2_o),
    .stallreq_o    (stallreq_o),
    .whilo_o       (whilo_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int dcnt      = 0;
  int stall_cnt = 0;
  bit chk_en    = 1'b0;

  // Reference model: one outstanding transaction with its write cycle timestamp
  bit          m_pend = 1'b0;
  int          m_w    = 0;
  logic        m_sgn  = 1'b0;
  logic [31:0] m_a    = 32'd0;
  logic [31:0] m_b    = 32'd0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive the divider stand-in, compare, advance the model
  task automatic tick();
    int   lat;
    bit   busy, done;
    logic rst_s, start_s;
    logic [63:0] r;
    lat = (div_opdata2_o == 32'd0) ? 3 : 35;
    div_ready_i  = (dcnt == lat);
    div_result_i = div_ready_i ? div_ref(div_signed_o, div_opdata1_o, div_opdata2_o)
                               : {$urandom(), $urandom()};
    #4;
    busy = m_pend && (cyc < m_w);
    done = m_pend && (cyc == m_w);
    if (chk_en) begin
      chk("start",   div_start_o,   busy && !flush_i);
      chk("annul",   div_annul_o,   busy && flush_i);
      chk("stall",   stallreq_o,    (!m_pend && div_req_i && !flush_i) || (busy && !flush_i));
      chk("whilo",   whilo_o,       done);
      chk("hi",      hi_o,          m_hi);
      chk("lo",      lo_o,          m_lo);
      chk("signed",  div_signed_o,  m_sgn);
      chk("opdata1", div_opdata1_o, m_a);
      chk("opdata2", div_opdata2_o, m_b);
      if (stallreq_o === 1'b1) stall_cnt++;
    end
    rst_s   = rst;
    start_s = div_start_o;
    if (rst_s) begin
      m_pend = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
      m_a = 32'd0; m_b = 32'd0; m_sgn = 1'b0;
    end else if (m_pend) begin
      if (done || flush_i) begin
        m_pend = 1'b0;
      end else if (cyc + 1 == m_w) begin
        r = div_ref(m_sgn, m_a, m_b);
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
    end else if (div_req_i && !flush_i) begin
      m_pend = 1'b1;
      m_sgn  = div_signed_i;
      m_a    = reg1_i;
      m_b    = reg2_i;
      m_w    = cyc + 1 + ((reg2_i == 32'd0) ? 4 : 36);
    end
    @(posedge clk);
    #1;
    cyc++;
    dcnt = (rst_s || !start_s) ? 0 : dcnt + 1;
  endtask

  // Issue one division; flush_at > 0 flushes on that BUSY cycle instead
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int flush_at,
                        output int lat, output bit wrote, output logic [31:0] hi, output logic [31:0] lo);
    int req_c;
    lat = 0; wrote = 1'b0; hi = 32'd0; lo = 32'd0;
    stall_cnt = 0;
    req_c = cyc;
    div_req_i = 1'b1; div_signed_i = s; reg1_i = a; reg2_i = b; flush_i = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (whilo_o === 1'b1) begin
        wrote = 1'b1; lat = cyc - req_c; hi = hi_o; lo = lo_o;
        div_req_i = 1'b0;
        tick();
        return;
      end
      if (n == flush_at) begin
        div_req_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        return;
      end
      reg1_i = $urandom(); reg2_i = $urandom(); div_signed_i = 1'($urandom_range(0, 1));
    end
    checks++; failures++;
    $display("FAIL op_timeout cyc=%0d got=no_write expected=write", cyc);
  endtask

  int          lat, t1, t2;
  bit          wrote;
  logic [31:0] hi, lo, h1, l1, h2, l2;

  initial begin
    rst = 1'b1; div_req_i = 1'b0; div_signed_i = 1'b0; flush_i = 1'b0;
    reg1_i = 32'd0; reg2_i = 32'd0; div_ready_i = 1'b0; div_result_i = 64'd0;
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_whilo", whilo_o, 1'b0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_stall", stallreq_o, 1'b0);

    run_op(1'b0, 32'd100, 32'd7, 0, lat, wrote, hi, lo);
    chk("u_lat", lat, 37);
    chk("u_stall_cycles", stall_cnt, 37);
    chk("u_hi", hi, 32'h00000002);
    chk("u_lo", lo, 32'h0000000E);

    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, lat, wrote, hi, lo);
    chk("s_ovf_lo", lo, 32'h80000000);
    chk("s_ovf_hi", hi, 32'h00000000);

    run_op(1'b0, 32'h1234, 32'd0, 0, lat, wrote, hi, lo);
    chk("z_lat_from_accept", lat - 1, 4);
    chk("z_hi", hi, 32'd0);
    chk("z_lo", lo, 32'd0);

    run_op(1'b0, 32'd1000, 32'd3, 10, lat, wrote, hi, lo);
    chk("flush_nowrite", wrote, 1'b0);
    run_op(1'b0, 32'd9, 32'd3, 0, lat, wrote, hi, lo);
    chk("after_flush_lo", lo, 32'd3);
    chk("after_flush_hi", hi, 32'd0);

    run_op(1'b0, 32'd77, 32'd5, 36, lat, wrote, hi, lo);
    chk("flush_ready_nowrite", wrote, 1'b0);

    // Back-to-back with the request held through the first write
    t1 = -1; t2 = -1;
    div_req_i = 1'b1; div_signed_i = 1'b0; reg1_i = 32'd100; reg2_i = 32'd7;
    for (int n = 0; n < 120 && t2 < 0; n++) begin
      tick();
      if (whilo_o === 1'b1) begin
        if (t1 < 0) begin
          t1 = cyc; h1 = hi_o; l1 = lo_o; reg1_i = 32'd50; reg2_i = 32'd5;
        end else begin
          t2 = cyc; h2 = hi_o; l2 = lo_o; div_req_i = 1'b0;
        end
      end
    end
    tick();
    chk("b2b_gap", t2 - t1, 38);
    chk("b2b_hi1", h1, 32'd2);
    chk("b2b_lo1", l1, 32'd14);
    chk("b2b_hi2", h2, 32'd0);
    chk("b2b_lo2", l2, 32'd10);

    // Reset in the middle of a division
    div_req_i = 1'b1; div_signed_i = 1'b1; reg1_i = 32'd100; reg2_i = 32'd7;
    for (int n = 0; n < 6; n++) tick();
    rst = 1'b1; div_req_i = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_whilo", whilo_o, 1'b0);
    chk("mid_rst_hi", hi_o, 32'd0);
    chk("mid_rst_lo", lo_o, 32'd0);
    chk("mid_rst_op1", div_opdata1_o, 32'd0);
    chk("mid_rst_op2", div_opdata2_o, 32'd0);
    chk("mid_rst_signed", div_signed_o, 1'b0);
    chk("mid_rst_start", div_start_o, 1'b0);
    chk("mid_rst_annul", div_annul_o, 1'b0);
    chk("mid_rst_stall", stallreq_o, 1'b0);

    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0, lat, wrote, hi, lo);
    chk("s_lo", lo, 32'hFFFFFFFD);
    chk("s_hi", hi, 32'hFFFFFFFF);

    // Randomized traffic: requests, flushes, resets and zero divisors
    for (int i = 0; i < 3000; i++) begin
      div_req_i    = ($urandom_range(0, 3) != 0);
      flush_i      = ($urandom_range(0, 49) == 0);
      rst          = ($urandom_range(0, 499) == 0);
      div_signed_i = 1'($urandom_range(0, 1));
      reg1_i       = $urandom();
      case ($urandom_range(0, 9))
        0:       reg2_i = 32'd0;
        1, 2, 3: reg2_i = $urandom_range(1, 20);
        4:       reg2_i = 32'hFFFFFFFF;
        default: reg2_i = $urandom();
      endcase
      tick();
    end
    rst = 1'b0; div_req_i = 1'b0; flush_i = 1'b0;
    for (int n = 0; n < 40; n++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
